data_mem_ctrl: RTL
==================

Name: data_mem_ctrl

Overview:
- M-stage data memory controller between the pipelined datapath and a multi-cycle data bus (req/ack handshake).
- Formats loads and stores by func3: byte lanes, byte enables, sign/zero extension.
- Stalls the pipeline while a bus transaction is outstanding.
- Flags misaligned accesses, illegal func3 and bus timeouts.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for mem_ack before abort (≥1).
- CNT_W, 5: width of timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memReadM  in  1  load in M stage.
- memWriteM  in  1  store in M stage.
- func3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addrM  in  32  byte address (ALUResultM).
- writeDataM  in  32  store data, right-aligned.
- readDataM  out  32  extended load result to MEM/WB.
- stallM  out  1  hold F/D/E/M stages.
- faultM  out  1  one-cycle pulse: misaligned, illegal func3 or timeout.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address; bits [1:0] always 0.
- mem_wdata  out  32  lane-shifted store data.
- mem_be  out  4  byte enables (write only; 0 on reads).
- mem_rdata  in  32  bus read word, valid with mem_ack.
- mem_ack  in  1  one-cycle transfer completion.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0. mem_req/mem_we/mem_be/mem_addr/mem_wdata, readDataM, stallM and faultM all 0.
- Access = memReadM|memWriteM. If both are set: write wins; read ignored.
- Legality:
  - func3 ∉ {000,001,010} for stores, or ∉ {000,001,010,100,101} for loads, is illegal.
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]≠0 is misaligned.
- FSM states IDLE, REQ, DONE.
- IDLE, legal access:
  - stallM=1 combinationally.
  - At the clock edge: latch addr/func3/we; compute mem_be and mem_wdata (data shifted by 8×addr[1:0]; b: be=1<<addr[1:0]; h: be=3<<addr[1:0]; w: be=1111).
  - Go REQ.
- IDLE, illegal access: no bus activity, stallM=0, faultM=1 same cycle (combinational), readDataM=0.
- REQ:
  - mem_req=1 and stallM=1; bus outputs stable until ack.
  - Counter increments each cycle.
  - mem_ack: capture mem_rdata, go DONE.
  - Counter reaches TIMEOUT with no ack: drop mem_req, set error flag, go DONE.
- DONE (exactly one cycle):
  - stallM=0, mem_req=0.
  - readDataM = extracted lane, extended (b/h sign-extend; bu/hu zero-extend; w as-is). 0 for stores or on timeout.
  - faultM=1 if timed out.
  - Next state IDLE; the pipeline advances on this edge.
- Latency: a load with ack in the first REQ cycle stalls for 2 cycles; result is valid in the DONE cycle.
- mem_ack outside REQ is ignored.
- Access inputs are sampled only in IDLE; changes during REQ are ignored.
- Reset mid-transaction: immediate IDLE, mem_req drops asynchronously, captured data is discarded.
- Back-to-back accesses: a new access is seen in IDLE the cycle after DONE. No bubble-free overlap.

Test Plan:
- lw addr 0x100, mem_rdata=0xDEADBEEF, ack after 3 REQ cycles → mem_addr=0x100, stallM high 4 cycles, readDataM=0xDEADBEEF in DONE.
- lb addr 0x203, rdata=0x80FF_FFFF → readDataM=0xFFFFFF80; lbu same → 0x00000080.
- sh addr 0x42, writeDataM=0x1234ABCD → mem_we=1, mem_be=1100, mem_wdata[31:16]=0xABCD, mem_addr=0x40.
- lw addr 0x102 → no mem_req, faultM=1 one cycle, stallM=0, readDataM=0; func3=011 load → same.
- lw, ack never arrives, TIMEOUT=16 → mem_req high exactly 16 cycles, then DONE with faultM=1, readDataM=0, stallM low.
- Drive rst=0 mid-REQ → mem_req, stallM drop without clock edge. After release, IDLE; a stale ack is ignored.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Purpose : M-stage data memory controller; formats loads/stores by func3 and runs a req/ack bus transaction.
// Latency : IDLE -> REQ (until mem_ack or TIMEOUT cycles) -> DONE (1 cycle); a 1-cycle ack gives 2 stall cycles.
// Backpressure: stallM holds the pipeline from the IDLE accept cycle through the last REQ cycle; released in DONE.
// Ports   : pipeline side memReadM/memWriteM/func3M/addrM/writeDataM in, readDataM/stallM/faultM out;
//           bus side mem_req/mem_we/mem_addr/mem_wdata/mem_be out, mem_rdata/mem_ack in. rst is async active-low.
module data_mem_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memReadM,
   input  logic        memWriteM,
   input  logic [2:0]  func3M,
   input  logic [31:0] addrM,
   input  logic [31:0] writeDataM,
   output logic [31:0] readDataM,
   output logic        stallM,
   output logic        faultM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [31:0]        addr_q, wdata_q, rdata_q;
   logic [3:0]         be_q;
   logic [2:0]         f3_q;
   logic [1:0]         off_q;
   logic               we_q, tmo_q;

   logic               access, f3_ok, misalign, legal;
   logic               ack_hit, tmo_hit;
   logic [3:0]         be_nxt;
   logic [31:0]        wdata_nxt, lane, ext;

   // ---------------- request decode ----------------
   assign access = memReadM | memWriteM;

   // Unsigned loads have no store counterpart; a store with both flags set wins over the load.
   always_comb begin
      f3_ok = 1'b0;
      case (func3M)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~memWriteM;
         default:                f3_ok = 1'b0;
      endcase
   end

   // func3[1:0] encodes size for both signed and unsigned variants.
   assign misalign = ((func3M[1:0] == 2'b01) && addrM[0]) ||
                     ((func3M[1:0] == 2'b10) && (addrM[1:0] != 2'b00));
   assign legal    = access & f3_ok & ~misalign;

   always_comb begin
      be_nxt = 4'b0000;
      if (memWriteM) begin
         case (func3M[1:0])
            2'b00:   be_nxt = 4'b0001 << addrM[1:0];
            2'b01:   be_nxt = 4'b0011 << addrM[1:0];
            default: be_nxt = 4'b1111;
         endcase
      end
   end

   assign wdata_nxt = memWriteM ? (writeDataM << {addrM[1:0], 3'b000}) : 32'h0;

   // Ack takes priority over a timeout landing in the same cycle.
   assign ack_hit = (state == REQ) && mem_ack;
   assign tmo_hit = (state == REQ) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (legal) state_nxt = REQ;
         REQ:     if (ack_hit || tmo_hit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- transaction datapath ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         be_q    <= 4'h0;
         f3_q    <= 3'h0;
         off_q   <= 2'h0;
         we_q    <= 1'b0;
         tmo_q   <= 1'b0;
      end else if (state == IDLE) begin
         cnt <= '0;
         if (legal) begin
            addr_q  <= {addrM[31:2], 2'b00};
            wdata_q <= wdata_nxt;
            rdata_q <= 32'h0;
            be_q    <= be_nxt;
            f3_q    <= func3M;
            off_q   <= addrM[1:0];
            we_q    <= memWriteM;
            tmo_q   <= 1'b0;
         end
      end else if (state == REQ) begin
         cnt <= cnt + 1'b1;
         if (ack_hit) rdata_q <= mem_rdata;
         if (tmo_hit) tmo_q   <= 1'b1;
      end
   end

   // ---------------- load extraction ----------------
   assign lane = rdata_q >> {off_q, 3'b000};

   always_comb begin
      ext = lane;
      case (f3_q)
         3'b000:  ext = {{24{lane[7]}},  lane[7:0]};
         3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ext = {24'h0, lane[7:0]};
         3'b101:  ext = {16'h0, lane[15:0]};
         default: ext = lane;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Bus outputs are gated by REQ so they read 0 everywhere else, including straight out of reset.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      mem_be    = 4'h0;
      stallM    = 1'b0;
      faultM    = 1'b0;
      readDataM = 32'h0;
      case (state)
         IDLE: begin
            stallM = legal;
            faultM = access & ~legal;
         end
         REQ: begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_be    = be_q;
            stallM    = 1'b1;
         end
         DONE: begin
            faultM = tmo_q;
            if (!we_q && !tmo_q) readDataM = ext;
         end
         default: ;
      endcase
   end

endmodule
